// File: rtl/ft_cmd_rx_pkg.sv
// Shared constants and state encodings for the FT2232H command receive path.
// The transmit framer uses the same flag bytes.
package ft_cmd_rx_pkg;

    localparam int FT_DATA_WIDTH = 8;
    localparam int FT_ADDR_WIDTH = 8;
    localparam logic [7:0] FT_START_FLAG = 8'h5A;
    localparam logic [7:0] FT_STOP_FLAG  = 8'hA5;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_TURN = 2'd1,
        BUS_READ = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        PRS_WAIT_START = 2'd0,
        PRS_GET_ADDR   = 2'd1,
        PRS_GET_DATA   = 2'd2,
        PRS_WAIT_STOP  = 2'd3
    } prs_state_e;

endpackage

// File: rtl/ft_cmd_rx_if.sv
// FT2232H read-side bus plus the decoded command handshake.
// slave = the receiver, master = FT2232H model / arbiter / command consumer.
interface ft_cmd_rx_if #(
    parameter int DATA_WIDTH = ft_cmd_rx_pkg::FT_DATA_WIDTH,
    parameter int ADDR_WIDTH = ft_cmd_rx_pkg::FT_ADDR_WIDTH
) ();
    logic                  rx_grant;
    logic                  ft_rxf_n_i;
    logic [DATA_WIDTH-1:0] ft_data_i;
    logic                  ft_oe_n_o;
    logic                  ft_rd_n_o;
    logic                  rx_busy;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  frame_err;

    modport slave (
        input  rx_grant, ft_rxf_n_i, ft_data_i, cmd_ready,
        output ft_oe_n_o, ft_rd_n_o, rx_busy, cmd_valid, cmd_addr, cmd_data, frame_err
    );

    modport master (
        output rx_grant, ft_rxf_n_i, ft_data_i, cmd_ready,
        input  ft_oe_n_o, ft_rd_n_o, rx_busy, cmd_valid, cmd_addr, cmd_data, frame_err
    );
endinterface

// File: rtl/ft_cmd_rx_frame_parser.sv
// Deframes START/ADDR/DATA/STOP byte streams into single-entry commands.
// A bad STOP byte pulses frame_err; a START in that slot resynchronises.
module ft_cmd_rx_frame_parser
    import ft_cmd_rx_pkg::*;
#(
    parameter int                    DATA_WIDTH = FT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] START_FLAG = DATA_WIDTH'(FT_START_FLAG),
    parameter logic [DATA_WIDTH-1:0] STOP_FLAG  = DATA_WIDTH'(FT_STOP_FLAG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    output logic                  frame_err_o
);

    prs_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d, cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d, cmd_data_q, cmd_data_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  frame_err_q, frame_err_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRS_WAIT_START;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next parser state, advanced only by accepted bytes
    always_comb begin
        state_d = state_q;
        if (byte_valid_i) begin
            case (state_q)
                PRS_WAIT_START: state_d = (byte_i == START_FLAG) ? PRS_GET_ADDR : PRS_WAIT_START;
                PRS_GET_ADDR:   state_d = PRS_GET_DATA;
                PRS_GET_DATA:   state_d = PRS_WAIT_STOP;
                PRS_WAIT_STOP:  state_d = (byte_i != STOP_FLAG && byte_i == START_FLAG)
                                          ? PRS_GET_ADDR : PRS_WAIT_START;
                default:        state_d = PRS_WAIT_START;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pending capture, command load/release and error pulse
    always_comb begin
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready_i;
        frame_err_d = 1'b0;
        if (byte_valid_i) begin
            case (state_q)
                PRS_WAIT_START: pend_addr_d = pend_addr_q;
                PRS_GET_ADDR:   pend_addr_d = byte_i[ADDR_WIDTH-1:0];
                PRS_GET_DATA:   pend_data_d = byte_i;
                PRS_WAIT_STOP: begin
                    if (byte_i == STOP_FLAG) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = pend_addr_q;
                        cmd_data_d  = pend_data_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default:        pend_addr_d = pend_addr_q;
            endcase
        end else begin
            frame_err_d = 1'b0;
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_data_o  = cmd_data_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ft_cmd_rx.sv
// FT2232H synchronous-FIFO read side: bus turnaround FSM feeding the frame parser.
// A pending command stalls further reads so no byte is ever dropped.
module ft_cmd_rx
    import ft_cmd_rx_pkg::*;
#(
    parameter int                    DATA_WIDTH = FT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] START_FLAG = DATA_WIDTH'(FT_START_FLAG),
    parameter logic [DATA_WIDTH-1:0] STOP_FLAG  = DATA_WIDTH'(FT_STOP_FLAG)
) (
    input  logic        clk,
    input  logic        rst,
    ft_cmd_rx_if.slave  bus
);

    bus_state_e            state_q, state_d;
    logic                  oe_n_q;
    logic                  rd_en;
    logic                  cmd_valid;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  frame_err;

    // Bus state and registered output enable (follows the next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            oe_n_q  <= (state_d == BUS_IDLE);
        end
    end

    // Bus next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: begin
                if (bus.rx_grant && !bus.ft_rxf_n_i && !cmd_valid) begin
                    state_d = BUS_TURN;
                end else begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_TURN: state_d = BUS_READ;
            BUS_READ: begin
                if (bus.ft_rxf_n_i || !bus.rx_grant || cmd_valid) begin
                    state_d = BUS_IDLE;
                end else begin
                    state_d = BUS_READ;
                end
            end
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Read strobe: drops the same cycle grant, data or space disappears
    always_comb begin
        rd_en = 1'b0;
        if (state_q == BUS_READ && !bus.ft_rxf_n_i && bus.rx_grant && !cmd_valid) begin
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

    ft_cmd_rx_frame_parser #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .START_FLAG (START_FLAG),
        .STOP_FLAG  (STOP_FLAG)
    ) u_parser (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (rd_en),
        .byte_i       (bus.ft_data_i),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (bus.cmd_ready),
        .cmd_addr_o   (cmd_addr),
        .cmd_data_o   (cmd_data),
        .frame_err_o  (frame_err)
    );

    assign bus.ft_oe_n_o = oe_n_q;
    assign bus.ft_rd_n_o = !rd_en;
    assign bus.rx_busy   = (state_q != BUS_IDLE);
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_data  = cmd_data;
    assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_ft_cmd_rx.sv
// Bench for ft_cmd_rx: FT2232H byte-queue model, vector table, corner sequences,
// and a randomized stream checked against an array-scanning deframer.
module tb_ft_cmd_rx;
    import ft_cmd_rx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ft_cmd_rx_if bus ();
    ft_cmd_rx dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  n;
        logic [1:0]  ncmd;
        logic [15:0] cmd;
        logic [1:0]  nerr;
    } vec_t;

    typedef struct packed {
        logic oe_n;
        logic rd_n;
        logic cv;
        logic busy;
    } tr_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  offered_q[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    tr_t         trace[$];
    int          err_cnt, acc_cnt, exp_err;
    logic        stall = 1'b0;
    logic        s_oe_n, s_rd_n, s_busy, s_cv, s_err;
    logic [7:0]  s_addr, s_data;
    logic        prev_cv = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
    logic [15:0] prev_cmd = 16'h0000;
    vec_t        vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive FT side at negedge, sample just before the rising edge.
    task automatic step();
        logic       rd_ok;
        logic [7:0] tmp;
        @(negedge clk);
        bus.ft_rxf_n_i = stall || (src_q.size() == 0);
        bus.ft_data_i  = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
        #4;
        s_oe_n = bus.ft_oe_n_o;
        s_rd_n = bus.ft_rd_n_o;
        s_busy = bus.rx_busy;
        s_cv   = bus.cmd_valid;
        s_err  = bus.frame_err;
        s_addr = bus.cmd_addr;
        s_data = bus.cmd_data;
        trace.push_back('{s_oe_n, s_rd_n, s_cv, s_busy});
        rd_ok = s_busy && !s_oe_n && bus.rx_grant && !bus.ft_rxf_n_i && !s_cv;
        check("rd_guard", 32'(!s_rd_n && !rd_ok), 32'd0);
        check("oe_vs_busy", 32'(s_oe_n), 32'(!s_busy));
        check("err_one_cycle", 32'(prev_err && s_err), 32'd0);
        if (prev_cv && !prev_ready && !rst) begin
            check("hold_valid", 32'(s_cv), 32'd1);
            check("hold_cmd", 32'({s_addr, s_data}), 32'(prev_cmd));
        end
        if (!s_rd_n && src_q.size() != 0) begin
            acc_q.push_back(bus.ft_data_i);
            tmp = src_q.pop_front();
            acc_cnt++;
        end
        if (s_cv && bus.cmd_ready) got_q.push_back({s_addr, s_data});
        if (s_err) err_cnt++;
        prev_cv    = s_cv;
        prev_ready = bus.cmd_ready;
        prev_err   = s_err;
        prev_cmd   = {s_addr, s_data};
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        acc_q.delete();
        trace.delete();
        err_cnt = 0;
        acc_cnt = 0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && src_q.size() != 0; k++) step();
        check("drain_empty", 32'(src_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic step_until_acc(input int target);
        for (int k = 0; k < 40 && acc_cnt < target; k++) step();
        check("reach_acc", 32'(acc_cnt), 32'(target));
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return 32'(got_q[i]);
        else return 32'hFFFF_FFFF;
    endfunction

    // Reference deframer: scan the offered byte array for frames.
    task automatic ref_model();
        int i;
        exp_q.delete();
        exp_err = 0;
        i = 0;
        while (i < offered_q.size()) begin
            if (offered_q[i] != 8'h5A) begin
                i++;
            end else if (i + 3 >= offered_q.size()) begin
                break;
            end else if (offered_q[i+3] == 8'hA5) begin
                exp_q.push_back({offered_q[i+1], offered_q[i+2]});
                i += 4;
            end else begin
                exp_err++;
                i += (offered_q[i+3] == 8'h5A) ? 3 : 4;
            end
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 19);
        if (r < 5) return 8'h5A;
        else if (r < 8) return 8'hA5;
        else return 8'($urandom);
    endfunction

    task automatic offer(input logic [7:0] b);
        src_q.push_back(b);
        offered_q.push_back(b);
    endtask

    initial begin
        int f_oe, f_rd, l_rd, n_rd, f_cv, n_cv, mark, r, n_bad;
        logic [7:0] g;

        rst = 1'b1;
        bus.rx_grant   = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.ft_rxf_n_i = 1'b1;
        bus.ft_data_i  = 8'h00;
        step();
        step();
        check("rst_oe_n", 32'(s_oe_n), 32'd1);
        check("rst_rd_n", 32'(s_rd_n), 32'd1);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_cv", 32'(s_cv), 32'd0);
        check("rst_addr", 32'(s_addr), 32'd0);
        check("rst_data", 32'(s_data), 32'd0);
        check("rst_err", 32'(s_err), 32'd0);
        rst = 1'b0;
        bus.rx_grant  = 1'b1;
        bus.cmd_ready = 1'b1;
        step();

        // Basic frame timing
        clear_mon();
        foreach (vt[0].bytes[k]) ; // no-op keeps loop vars local
        src_q = '{8'h5A, 8'h03, 8'h7E, 8'hA5};
        drain(40);
        f_oe = -1; f_rd = -1; l_rd = -1; n_rd = 0; f_cv = -1; n_cv = 0;
        for (int i = 0; i < trace.size(); i++) begin
            if (!trace[i].oe_n && f_oe < 0) f_oe = i;
            if (!trace[i].rd_n) begin
                if (f_rd < 0) f_rd = i;
                l_rd = i;
                n_rd++;
            end
            if (trace[i].cv) begin
                if (f_cv < 0) f_cv = i;
                n_cv++;
            end
        end
        check("t1_turn_before_rd", 32'(f_rd - f_oe), 32'd1);
        check("t1_rd_count", 32'(n_rd), 32'd4);
        check("t1_rd_consecutive", 32'(l_rd - f_rd), 32'd3);
        check("t1_cv_latency", 32'(f_cv - f_rd), 32'd4);
        check("t1_cv_cycles", 32'(n_cv), 32'd1);
        check("t1_cmd", got_at(0), 32'h037E);

        // Vector table
        vt[0] = '{64'h5A037EA5_00000000, 4'd4, 2'd1, 16'h037E, 2'd0};
        vt[1] = '{64'h5A102233_5A1144A5, 4'd8, 2'd1, 16'h1144, 2'd1};
        vt[2] = '{64'h5A5AA5A5_00000000, 4'd4, 2'd1, 16'h5AA5, 2'd0};
        vt[3] = '{64'h11225AA5_5AA50000, 4'd6, 2'd1, 16'hA55A, 2'd0};
        vt[4] = '{64'h5A010203_00000000, 4'd4, 2'd0, 16'h0000, 2'd1};
        vt[5] = '{64'h5A01025A_5A0102A5, 4'd8, 2'd0, 16'h0000, 2'd2};
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            for (int k = 0; k < int'(vt[v].n); k++) src_q.push_back(vt[v].bytes[63 - 8*k -: 8]);
            drain(60);
            check($sformatf("vec%0d_ncmd", v), 32'(got_q.size()), 32'(vt[v].ncmd));
            if (vt[v].ncmd != 2'd0) check($sformatf("vec%0d_cmd", v), got_at(0), 32'(vt[v].cmd));
            check($sformatf("vec%0d_nerr", v), 32'(err_cnt), 32'(vt[v].nerr));
            check($sformatf("vec%0d_acc", v), 32'(acc_cnt), 32'(vt[v].n));
        end

        // Back-pressure: second frame must wait for the first command
        clear_mon();
        bus.cmd_ready = 1'b0;
        src_q = '{8'h5A, 8'h0A, 8'h0B, 8'hA5, 8'h5A, 8'h0C, 8'h0D, 8'hA5};
        for (int k = 0; k < 20; k++) step();
        check("bp_acc_held", 32'(acc_cnt), 32'd4);
        check("bp_rd_high", 32'(s_rd_n), 32'd1);
        check("bp_cv", 32'(s_cv), 32'd1);
        check("bp_cmd", 32'({s_addr, s_data}), 32'h0A0B);
        check("bp_none_taken", 32'(got_q.size()), 32'd0);
        bus.cmd_ready = 1'b1;
        drain(60);
        check("bp_ncmd", 32'(got_q.size()), 32'd2);
        check("bp_first", got_at(0), 32'h0A0B);
        check("bp_second", got_at(1), 32'h0C0D);

        // FIFO empty for 7 cycles between ADDR and DATA
        clear_mon();
        src_q = '{8'h5A, 8'h21};
        step_until_acc(2);
        for (int k = 0; k < 7; k++) step();
        check("gap_acc", 32'(acc_cnt), 32'd2);
        check("gap_idle", 32'(s_busy), 32'd0);
        mark = trace.size();
        src_q = '{8'h43, 8'hA5};
        drain(40);
        f_rd = -1;
        for (int i = mark; i < trace.size(); i++) if (!trace[i].rd_n && f_rd < 0) f_rd = i;
        check("gap_reentry_turn", 32'({trace[f_rd-1].oe_n, trace[f_rd-1].rd_n}), 32'b01);
        check("gap_cmd", got_at(0), 32'h2143);
        check("gap_nerr", 32'(err_cnt), 32'd0);

        // Grant loss after ADDR
        clear_mon();
        src_q = '{8'h5A, 8'h31, 8'h42, 8'hA5};
        step_until_acc(2);
        bus.rx_grant = 1'b0;
        step();
        check("gl_rd_same_cycle", 32'(s_rd_n), 32'd1);
        check("gl_busy_still", 32'(s_busy), 32'd1);
        step();
        check("gl_busy_low", 32'({s_busy, s_oe_n}), 32'b01);
        for (int k = 0; k < 3; k++) step();
        check("gl_no_accept", 32'(acc_cnt), 32'd2);
        bus.rx_grant = 1'b1;
        drain(40);
        check("gl_cmd", got_at(0), 32'h3142);
        check("gl_nerr", 32'(err_cnt), 32'd0);

        // Reset during GET_DATA, then a clean frame
        clear_mon();
        src_q = '{8'h5A, 8'h55, 8'h66, 8'hA5};
        step_until_acc(2);
        rst = 1'b1;
        step();
        step();
        check("mr_oe_n", 32'(s_oe_n), 32'd1);
        check("mr_rd_n", 32'(s_rd_n), 32'd1);
        check("mr_busy", 32'(s_busy), 32'd0);
        check("mr_cv", 32'(s_cv), 32'd0);
        check("mr_cmd_zero", 32'({s_addr, s_data}), 32'd0);
        check("mr_err", 32'(s_err), 32'd0);
        rst = 1'b0;
        clear_mon();
        src_q.push_back(8'h5A); src_q.push_back(8'h77);
        src_q.push_back(8'h88); src_q.push_back(8'hA5);
        drain(40);
        check("mr_ncmd", 32'(got_q.size()), 32'd1);
        check("mr_cmd", got_at(0), 32'h7788);
        check("mr_nerr", 32'(err_cnt), 32'd0);

        // Randomized stream with stalls, grant loss and back-pressure
        clear_mon();
        src_q.delete();
        offered_q.delete();
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6 || it == 79) begin
                offer(8'h5A); offer(pick_byte()); offer(pick_byte()); offer(8'hA5);
            end else if (r < 8) begin
                offer(8'h5A); offer(pick_byte()); offer(pick_byte());
                do g = pick_byte(); while (g == 8'hA5);
                offer(g);
            end else begin
                do g = 8'($urandom); while (g == 8'h5A);
                offer(g);
            end
        end
        for (int k = 0; k < 8000 && src_q.size() != 0; k++) begin
            stall         = ($urandom_range(0, 4) == 0);
            bus.rx_grant  = ($urandom_range(0, 6) != 0);
            bus.cmd_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        stall = 1'b0;
        bus.rx_grant  = 1'b1;
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("rand_drained", 32'(src_q.size()), 32'd0);
        ref_model();
        check("rand_acc_count", 32'(acc_q.size()), 32'(offered_q.size()));
        n_bad = 0;
        for (int i = 0; i < acc_q.size() && i < offered_q.size(); i++)
            if (acc_q[i] != offered_q[i]) n_bad++;
        check("rand_byte_order", 32'(n_bad), 32'd0);
        check("rand_ncmd", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_cmd%0d", i), got_at(i), 32'(exp_q[i]));
        check("rand_nerr", 32'(err_cnt), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
